operand_entry: RTL and testbench
================================

# operand_entry

Front-end input block for the restoring-divider board design. Debounces two push-buttons, captures a 16-bit dividend and then a 16-bit divisor from the slide switches, and issues a single-cycle start to the divider core. It then waits for the divider's done pulse. It is the producer end of the divider datapath; the seven-segment controller is the consumer end and shows the resulting quotient and remainder.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive synchronized cycles a button level must hold before it is accepted (10 ms at 100 MHz). Simulation uses 4. Legal range is ≥ 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  16  raw slide switches, operand value. Asynchronous; 2-FF synchronized internally.
- btn_load  in  1  raw push-button, asynchronous. Captures the next operand.
- btn_start  in  1  raw push-button, asynchronous. Launches the division.
- div_done  in  1  one-cycle pulse from the divider core when the result is valid.
- dividend  out  16  registered dividend to the divider.
- divisor  out  16  registered divisor to the divider.
- div_start  out  1  registered, one-cycle start pulse to the divider.
- err_div0  out  1  sticky flag: a start was refused because divisor == 0.
- state_o  out  3  current FSM state for the LEDs: IDLE=0, GOT_DVD=1, READY=2, WAIT=3, DONE=4.

## Operation
- Each button path:
  - Passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer has a counter and a `stable` register.
  - The counter increments while the synchronized level ≠ `stable`. It clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1 with the levels still unequal, `stable` takes the synchronized level and the counter clears.
  - A press pulse is `stable & ~stable_q`. It is high for exactly one cycle per accepted rising edge.
  - Releases and glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- sw is 2-FF synchronized. The synchronized value is what gets captured.
- FSM transitions (on press pulses; presses not listed for a state are ignored):
  - IDLE, load press: dividend ← sw, → GOT_DVD.
  - GOT_DVD, load press: divisor ← sw, → READY.
  - READY, start press with divisor ≠ 0: div_start = 1 for one cycle, → WAIT.
  - READY, start press with divisor == 0: err_div0 ← 1, stay in READY, no div_start.
  - READY, load press: dividend ← sw, err_div0 ← 0, → GOT_DVD (re-entry).
  - WAIT: all button presses ignored. div_done → DONE.
  - DONE, load press: dividend ← sw, err_div0 ← 0, → GOT_DVD.
  - DONE, start press: div_start pulse with the same operands, → WAIT.
- Simultaneous load and start presses:
  - In READY and DONE, start wins and the load press is dropped.
  - In IDLE and GOT_DVD, load is acted on.
- div_done received in any state other than WAIT is ignored.
- dividend and divisor change only on capture. They are stable throughout WAIT and DONE.

## Timing
- Reset (asynchronous, rst_n low):
  - FSM → IDLE.
  - dividend = 0, divisor = 0, div_start = 0, err_div0 = 0, state_o = 0.
  - Debounce counters, `stable` and synchronizers all clear.
- Reset mid-operation (any state, including WAIT) aborts to IDLE immediately. No div_start is emitted afterwards.
- Button latency, with the raw level first sampled high at edge k:
  - The synchronizer output rises at edge k+1.
  - `stable` rises at edge k+1+DEBOUNCE_CYCLES.
  - The press pulse is high for the following cycle.
  - The FSM acts (capture or state change) at edge k+2+DEBOUNCE_CYCLES.
- div_start is high in the cycle immediately after the FSM edge that leaves READY or DONE. It is never high for two consecutive cycles.
- div_done → DONE takes effect on the edge that samples div_done high. state_o is valid the next cycle.
- state_o and err_div0 are registered with no combinational path from inputs.

## Test plan
- Bench settings: DEBOUNCE_CYCLES = 4. Each "press" holds the button for 20 cycles; each "bounce" is 3-cycle on/off chatter.
- Reset, then press load with sw = 0x00C8 and press load with sw = 0x0007 → dividend = 0x00C8, divisor = 0x0007, state_o = 2. Capture lands exactly 6 edges after the raw press is first sampled.
- From READY, press start → exactly one div_start cycle and state_o = 3. Pulse div_done after 17 cycles → state_o = 4, operands unchanged.
- Divisor = 0x0000, press start → err_div0 = 1, no div_start, state_o = 2. Then press load with sw = 0x0010 → err_div0 = 0, dividend = 0x0010, state_o = 1.
- Apply 3-cycle bounce chatter on btn_load in IDLE → no capture, state_o = 0. Pulse div_done while in IDLE → ignored.
- In WAIT, press load and start, then assert rst_n = 0 for 2 cycles → all outputs return to reset values at once and no div_start appears afterwards. In DONE, press load and start together → div_start pulse, state_o = 3, dividend unchanged.

Source files
------------

// File: rtl/operand_entry.sv
// Operand entry front end for the restoring divider: debounced buttons capture
// a dividend then a divisor from the switches and launch/track one division.
module operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        btn_load,
  input  logic        btn_start,
  input  logic        div_done,
  output logic [15:0] dividend,
  output logic [15:0] divisor,
  output logic        div_start,
  output logic        err_div0,
  output logic [2:0]  state_o
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NBTN   = 2;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned BTN_LD = 0;
  localparam int unsigned BTN_ST = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT_DVD = 3'd1,
    ST_READY   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  logic [NBTN-1:0]   btn_raw;
  logic [NBTN-1:0]   btn_meta_q;
  logic [NBTN-1:0]   btn_sync_q;
  logic [NBTN-1:0]   press;
  logic [DATA_W-1:0] sw_meta_q;
  logic [DATA_W-1:0] sw_sync_q;

  assign btn_raw = {btn_start, btn_load};

  // Two-flop synchronizers for the asynchronous switch and button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;

    // A new level is accepted only after it has differed from stable for DEBOUNCE_CYCLES edges
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (btn_sync_q[g] != stable_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = btn_sync_q[g];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q         <= '0;
        stable_q      <= 1'b0;
        stable_prev_q <= 1'b0;
      end else begin
        cnt_q         <= cnt_d;
        stable_q      <= stable_d;
        stable_prev_q <= stable_q;
      end
    end

    assign press[g] = stable_q & ~stable_prev_q;
  end

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] dividend_d;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] divisor_d;
  logic              start_q;
  logic              start_d;
  logic              err_q;
  logic              err_d;
  logic              press_ld;
  logic              press_st;

  assign press_ld = press[BTN_LD];
  assign press_st = press[BTN_ST];

  // Next-state and registered-output logic; start has priority over load where both apply
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    start_d    = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press_ld) begin
          dividend_d = sw_sync_q;
          state_d    = ST_GOT_DVD;
        end
      end
      ST_GOT_DVD: begin
        if (press_ld) begin
          divisor_d = sw_sync_q;
          state_d   = ST_READY;
        end
      end
      ST_READY: begin
        if (press_st) begin
          if (divisor_q != '0) begin
            start_d = 1'b1;
            state_d = ST_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end else if (press_ld) begin
          dividend_d = sw_sync_q;
          err_d      = 1'b0;
          state_d    = ST_GOT_DVD;
        end
      end
      ST_WAIT: begin
        if (div_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (press_st) begin
          start_d = 1'b1;
          state_d = ST_WAIT;
        end else if (press_ld) begin
          dividend_d = sw_sync_q;
          err_d      = 1'b0;
          state_d    = ST_GOT_DVD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      start_q    <= start_d;
      err_q      <= err_d;
    end
  end

  assign dividend  = dividend_q;
  assign divisor   = divisor_q;
  assign div_start = start_q;
  assign err_div0  = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus random button/switch traffic,
// all outputs compared every cycle against a run-length behavioural model.
module tb_operand_entry;

  localparam int unsigned DC = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [15:0] sw        = '0;
  logic        btn_load  = 1'b0;
  logic        btn_start = 1'b0;
  logic        div_done  = 1'b0;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        div_start;
  logic        err_div0;
  logic [2:0]  state_o;

  operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_start (btn_start),
    .div_done  (div_done),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_start (div_start),
    .err_div0  (err_div0),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw buttons reach the debouncer two edges late; a level is
  // accepted on the DC-th consecutive edge it disagrees with the accepted level.
  int          m_st;
  logic [15:0] m_dvd, m_dvs;
  logic        m_start, m_err;
  logic [1:0]  m_s1, m_s2, m_stab, m_stabp;
  int          m_run [2];
  logic [15:0] m_sw1, m_sw2;
  logic        m_pl, m_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_dvd = '0; m_dvs = '0; m_start = 1'b0; m_err = 1'b0;
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_stabp = '0;
      m_run[0] = 0; m_run[1] = 0; m_sw1 = '0; m_sw2 = '0;
    end else begin
      m_pl = m_stab[0] & ~m_stabp[0];
      m_ps = m_stab[1] & ~m_stabp[1];
      m_start = 1'b0;
      case (m_st)
        0: if (m_pl) begin m_dvd = m_sw2; m_st = 1; end
        1: if (m_pl) begin m_dvs = m_sw2; m_st = 2; end
        2: if (m_ps) begin
             if (m_dvs != 0) begin m_start = 1'b1; m_st = 3; end
             else m_err = 1'b1;
           end else if (m_pl) begin m_dvd = m_sw2; m_err = 1'b0; m_st = 1; end
        3: if (div_done) m_st = 4;
        4: if (m_ps) begin m_start = 1'b1; m_st = 3; end
           else if (m_pl) begin m_dvd = m_sw2; m_err = 1'b0; m_st = 1; end
        default: m_st = 0;
      endcase
      m_stabp = m_stab;
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == int'(DC)) begin
            m_stab[b] = m_s2[b];
            m_run[b]  = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_start, btn_load};
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc dividend", 32'(dividend), 32'(m_dvd));
      chk("cyc divisor", 32'(divisor), 32'(m_dvs));
      chk("cyc div_start", 32'(div_start), 32'(m_start));
      chk("cyc err_div0", 32'(err_div0), 32'(m_err));
      chk("cyc state_o", 32'(state_o), 32'(m_st));
    end
    if (div_start === 1'b1) n_starts++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic press(input bit l, input bit s, input int hold, input int gap);
    if (l) btn_load = 1'b1;
    if (s) btn_start = 1'b1;
    tick(hold);
    btn_load  = 1'b0;
    btn_start = 1'b0;
    tick(gap);
  endtask

  task automatic pulse_done();
    div_done = 1'b1;
    tick(1);
    div_done = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dividend"}, 32'(dividend), 32'h0);
    chk({tag, " divisor"}, 32'(divisor), 32'h0);
    chk({tag, " div_start"}, 32'(div_start), 32'h0);
    chk({tag, " err_div0"}, 32'(err_div0), 32'h0);
    chk({tag, " state_o"}, 32'(state_o), 32'h0);
  endtask

  initial begin
    int op;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    at_neg();
    chk_reset_outputs("reset");

    // Dividend 0x00C8, then divisor 0x0007 with exact capture latency
    tick(1);
    sw = 16'h00C8;
    press(1, 0, 20, 12);
    sw = 16'h0007;
    btn_load = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("pre-capture state", 32'(state_o), 32'd1);
    @(posedge clk);
    #1 chk("capture at k+6 state", 32'(state_o), 32'd2);
    #1 tick(13);
    btn_load = 1'b0;
    tick(12);
    at_neg();
    chk("lit dividend C8", 32'(dividend), 32'h00C8);
    chk("lit divisor 7", 32'(divisor), 32'h0007);

    // Start, then done after 17 cycles
    tick(1);
    n_starts = 0;
    press(0, 1, 20, 12);
    at_neg();
    chk("single start pulse", 32'(n_starts), 32'd1);
    chk("wait state", 32'(state_o), 32'd3);
    tick(17);
    pulse_done();
    at_neg();
    chk("done state", 32'(state_o), 32'd4);
    chk("done dividend kept", 32'(dividend), 32'h00C8);
    chk("done divisor kept", 32'(divisor), 32'h0007);

    // Divide-by-zero refusal, then reload clears the flag
    tick(1);
    sw = 16'h0055;
    press(1, 0, 20, 12);
    sw = 16'h0000;
    press(1, 0, 20, 12);
    n_starts = 0;
    press(0, 1, 20, 12);
    at_neg();
    chk("div0 err set", 32'(err_div0), 32'd1);
    chk("div0 no start", 32'(n_starts), 32'd0);
    chk("div0 stays ready", 32'(state_o), 32'd2);
    tick(1);
    sw = 16'h0010;
    press(1, 0, 20, 12);
    at_neg();
    chk("reload err clear", 32'(err_div0), 32'd0);
    chk("reload dividend", 32'(dividend), 32'h0010);
    chk("reload state", 32'(state_o), 32'd1);

    // Bounce chatter in IDLE and a stray done pulse
    tick(1);
    do_reset(2);
    sw = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      btn_load = 1'b1;
      tick(3);
      btn_load = 1'b0;
      tick(3);
    end
    tick(10);
    at_neg();
    chk("bounce no capture state", 32'(state_o), 32'd0);
    chk("bounce no capture dvd", 32'(dividend), 32'h0);
    tick(1);
    pulse_done();
    tick(2);
    at_neg();
    chk("stray done ignored", 32'(state_o), 32'd0);

    // Reset while in WAIT with both buttons pressed
    tick(1);
    sw = 16'h0100;
    press(1, 0, 20, 12);
    sw = 16'h0003;
    press(1, 0, 20, 12);
    press(0, 1, 20, 12);
    btn_load = 1'b1;
    btn_start = 1'b1;
    tick(8);
    rst_n = 1'b0;
    at_neg();
    chk_reset_outputs("mid-wait reset");
    tick(1);
    btn_load = 1'b0;
    btn_start = 1'b0;
    tick(1);
    rst_n = 1'b1;
    n_starts = 0;
    tick(30);
    at_neg();
    chk("no start after reset", 32'(n_starts), 32'd0);
    chk("idle after reset", 32'(state_o), 32'd0);

    // Simultaneous load+start in DONE: start wins
    tick(1);
    press(1, 0, 20, 12);
    sw = 16'h0009;
    press(1, 0, 20, 12);
    press(0, 1, 20, 12);
    pulse_done();
    tick(2);
    at_neg();
    chk("reach done", 32'(state_o), 32'd4);
    tick(1);
    sw = 16'hBEEF;
    n_starts = 0;
    press(1, 1, 20, 12);
    at_neg();
    chk("both: one start", 32'(n_starts), 32'd1);
    chk("both: wait", 32'(state_o), 32'd3);
    chk("both: dividend kept", 32'(dividend), 32'h0003);

    // Randomized traffic, checked only by the per-cycle model compare
    tick(1);
    for (int it = 0; it < 300; it++) begin
      op = int'($urandom_range(0, 9));
      sw = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if (op <= 5) begin
        press(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              int'($urandom_range(1, 24)), int'($urandom_range(0, 14)));
      end else if (op <= 7) begin
        tick(int'($urandom_range(0, 20)));
        pulse_done();
      end else if (op == 8) begin
        tick(int'($urandom_range(1, 10)));
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end
    end
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
